// File: rtl/seg_bcd_scan.sv
// seg_bcd_scan: display back-end for an 8-bit CPU display register.
//   - Sequential double-dabble converts din (0..255) into three BCD digits,
//     one shift-add-3 iteration per clock; the result is committed to bcd
//     only once all 8 iterations are done.
//   - A free-running refresh counter time-multiplexes the three digits onto
//     one shared active-low segment bus.
//
// Handshake: none. din is a level. A conversion starts whenever din differs
// from the last captured value while idle; changes while busy are picked up
// once the current conversion has committed, so the newest value always wins.
//
// Optional build macro: SEG_LZB_EN enables leading-zero blanking of the
// hundreds and tens digits. bcd, busy and an are unaffected by it.
module seg_bcd_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  output logic [7:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Conversion engine state
  state_t      state_q, state_d;
  logic [7:0]  last_din_q, last_din_d;
  logic [7:0]  sh_q, sh_d;
  logic [11:0] work_q, work_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        busy_q, busy_d;

  // Scan / display state
  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    digit_q;
  logic [2:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  // One double-dabble step: correct each nibble >= 5, then shift in sh MSB
  logic [11:0] work_adj;
  logic [11:0] work_shift;

  // Seven-segment code for one BCD digit; anything above 9 is blank.
  function automatic logic [7:0] seg_code(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Add-3 correction followed by the left shift of {work, sh}
  always_comb begin
    work_adj   = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
    work_shift = {work_adj[10:0], sh_q[7]};
  end

  // Conversion FSM: next-state and datapath
  always_comb begin
    state_d    = state_q;
    last_din_d = last_din_q;
    sh_d       = sh_q;
    work_d     = work_q;
    bit_cnt_d  = bit_cnt_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (din != last_din_q) begin
          sh_d       = din;
          last_din_d = din;
          work_d     = 12'h000;
          bit_cnt_d  = 3'd0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        work_d    = work_shift;
        sh_d      = {sh_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          // Eighth iteration: the freshly shifted value is the full result
          bcd_d   = work_shift;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Conversion FSM: state register, asynchronous reset aborts any conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_din_q <= 8'h00;
      sh_q       <= 8'h00;
      work_q     <= 12'h000;
      bit_cnt_q  <= 3'd0;
      bcd_q      <= 12'h000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_din_q <= last_din_d;
      sh_q       <= sh_d;
      work_q     <= work_d;
      bit_cnt_q  <= bit_cnt_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
    end
  end

  // Refresh counter and digit index; never stalls, even while converting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= 2'd0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      digit_q    <= (digit_q == 2'd2) ? 2'd0 : (digit_q + 2'd1);
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Digit enable and segment pattern for the currently selected digit
  always_comb begin
    an_d = 3'b001;
    case (digit_q)
      2'd0:    an_d = 3'b001;
      2'd1:    an_d = 3'b010;
      2'd2:    an_d = 3'b100;
      default: an_d = 3'b001;
    endcase
    seg_d = 8'hFF;
    case (digit_q)
      2'd0: seg_d = seg_code(bcd_q[3:0]);
      2'd1: begin
`ifdef SEG_LZB_EN
        if (bcd_q[11:4] == 8'h00) seg_d = 8'hFF;
        else                      seg_d = seg_code(bcd_q[7:4]);
`else
        seg_d = seg_code(bcd_q[7:4]);
`endif
      end
      2'd2: begin
`ifdef SEG_LZB_EN
        if (bcd_q[11:8] == 4'h0) seg_d = 8'hFF;
        else                     seg_d = seg_code(bcd_q[11:8]);
`else
        seg_d = seg_code(bcd_q[11:8]);
`endif
      end
      default: seg_d = 8'hFF;
    endcase
  end

  // Registered display outputs, one cycle behind the digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 3'b001;
      seg_q <= 8'hC0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Bench for seg_bcd_scan with SCAN_DIV=4. A behavioural model (decimal
// arithmetic, edge counting) predicts every output each cycle; a few literal
// checks pin the model to hand-computed values.
module tb_seg_bcd_scan;

  localparam int SD = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic [7:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  always #5 clk = ~clk;

  seg_bcd_scan #(.SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .seg  (seg),
    .an   (an),
    .bcd  (bcd),
    .busy (busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  // ---------------- model ----------------
  function automatic logic [7:0] seg_code(input int d);
    logic [7:0] c;
    case (d)
      0: c = 8'hC0; 1: c = 8'hF9; 2: c = 8'hA4; 3: c = 8'hB0; 4: c = 8'h99;
      5: c = 8'h92; 6: c = 8'h82; 7: c = 8'hF8; 8: c = 8'h80; 9: c = 8'h90;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pattern for digit position dig (0=units) of decimal value v
  function automatic logic [7:0] exp_seg(input int v, input int dig);
    int h, t, u;
    logic [7:0] r;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    r = 8'hFF;
    case (dig)
      0: r = seg_code(u);
`ifdef SEG_LZB_EN
      1: r = (h == 0 && t == 0) ? 8'hFF : seg_code(t);
      2: r = (h == 0) ? 8'hFF : seg_code(h);
`else
      1: r = seg_code(t);
      2: r = seg_code(h);
`endif
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  int         m_n     = 0;   // clock edges since reset
  int         m_shown = 0;   // committed decimal value
  logic       m_busy  = 1'b0;
  int         m_left  = 0;   // edges until commit
  int         m_val   = 0;
  int         m_last  = 0;
  logic [2:0] m_an    = 3'b001;
  logic [7:0] m_seg   = 8'hC0;

  initial begin
    int dig;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_shown = 0; m_busy = 1'b0; m_left = 0; m_val = 0;
        m_last = 0; m_an = 3'b001; m_seg = 8'hC0;
      end else begin
        dig   = (m_n / SD) % 3;
        m_an  = 3'(1 << dig);
        m_seg = exp_seg(m_shown, dig);
        m_n++;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_shown = m_val;
            m_busy  = 1'b0;
          end
        end else if (int'(din) != m_last) begin
          m_last = int'(din);
          m_val  = int'(din);
          m_busy = 1'b1;
          m_left = 8;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        cmp("bcd",  bcd,          to_bcd(m_shown));
        cmp("busy", {11'd0, busy}, {11'd0, m_busy});
        cmp("an",   {9'd0, an},    {9'd0, m_an});
        cmp("seg",  {4'd0, seg},   {4'd0, m_seg});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic val, input int budget);
    int n;
    n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_busy: busy=%b expected %b within %0d cycles", busy, val, budget);
    end
  endtask

  task automatic wait_an(input logic [2:0] want);
    int n;
    n = 0;
    while (an !== want && n < 3 * SD + 2) begin
      @(negedge clk);
      n++;
    end
    if (an !== want) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_an: an=%b expected %b", an, want);
    end
  endtask

  task automatic convert(input logic [7:0] v);
    @(negedge clk);
    din = v;
    @(negedge clk);
    wait_busy(1'b0, 20);
  endtask

  task automatic check_digits(input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0);
    repeat (2) @(negedge clk);
    wait_an(3'b100); cmp("seg_hund",  {4'd0, seg}, {4'd0, s2});
    wait_an(3'b010); cmp("seg_tens",  {4'd0, seg}, {4'd0, s1});
    wait_an(3'b001); cmp("seg_units", {4'd0, seg}, {4'd0, s0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    din = 8'd0;
    #1;
    cmp("rst_bcd",  bcd,           12'h000);
    cmp("rst_busy", {11'd0, busy}, 12'h000);
    cmp("rst_an",   {9'd0, an},    12'h001);
    cmp("rst_seg",  {4'd0, seg},   12'h0C0);
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // din=0: nothing to convert, display "000" scans
    repeat (3 * SD * 2) @(negedge clk);
    cmp("idle_busy", {11'd0, busy}, 12'h000);
    check_digits(8'hC0, 8'hC0, 8'hC0);

    // 255: busy for 8 cycles, then "255"
    @(negedge clk);
    din = 8'd255;
    @(negedge clk);
    cmp("b255_busy", {11'd0, busy}, 12'h001);
    repeat (7) @(negedge clk);
    cmp("b255_still", {11'd0, busy}, 12'h001);
    @(negedge clk);
    cmp("b255_bcd", bcd, 12'h255);
    check_digits(8'hA4, 8'h92, 8'h92);

    // 7: leading zeros shown or blanked depending on build
    convert(8'd7);
    cmp("b7_bcd", bcd, 12'h007);
`ifdef SEG_LZB_EN
    check_digits(8'hFF, 8'hFF, 8'hF8);
`else
    check_digits(8'hC0, 8'hC0, 8'hF8);
`endif

    // 100 then 42 while busy: 100 commits, then 42 recaptured next edge
    @(negedge clk);
    din = 8'd100;
    @(negedge clk);
    repeat (3) @(negedge clk);
    din = 8'd42;
    wait_busy(1'b0, 20);
    cmp("b100_bcd", bcd, 12'h100);
    @(negedge clk);
    cmp("recap_busy", {11'd0, busy}, 12'h001);
    wait_busy(1'b0, 20);
    cmp("b42_bcd", bcd, 12'h042);

    // 199 with reset at iteration 4
    @(negedge clk);
    din = 8'd199;
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("arst_bcd",  bcd,           12'h000);
    cmp("arst_busy", {11'd0, busy}, 12'h000);
    cmp("arst_an",   {9'd0, an},    12'h001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("b199_busy", {11'd0, busy}, 12'h001);
    repeat (7) @(negedge clk);
    cmp("b199_hold", bcd, 12'h000);
    @(negedge clk);
    cmp("b199_bcd", bcd, 12'h199);

    // Sweep every input value
    for (int v = 0; v < 256; v++) begin
      convert(8'(v));
      cmp("sweep_bcd", bcd, to_bcd(v));
    end

    // Random changes, including during conversions
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) din = 8'($urandom_range(0, 255));
    end
    wait_busy(1'b0, 40);
    repeat (3 * SD) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_bcd_scan.md
Name: seg_bcd_scan

Overview:
- Display back-end between the CPU's registered 8-bit display output and the board's multiplexed 3-digit seven-segment display.
- Converts the unsigned 8-bit value to 3 BCD digits with a sequential double-dabble (shift-add-3) engine.
- Time-multiplexes the digits onto one shared segment bus with a refresh counter.

Parameters:
- SCAN_DIV, 1000, clk cycles each digit stays enabled; legal range ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- din  in  8  value to display (CPU display register, unsigned 0..255)
- seg  out  8  segment bus, active-low; bit0=a..bit6=g, bit7=dp (always 1)
- an  out  3  digit enable, one-hot, active-high; bit0=units, bit1=tens, bit2=hundreds
- bcd  out  12  committed BCD result {hundreds, tens, units}
- busy  out  1  conversion in progress

Behaviour:
- Reset values: bcd=12'h000, busy=0, an=3'b001, seg=8'hC0 ("0" on units), internal last_din=0, state IDLE, scan counter=0, digit index=0.
- FSM states: IDLE, CONV.
- IDLE:
  - If din != last_din at an edge: sh<=din, last_din<=din, bit counter<=0, state<=CONV, busy<=1.
  - Otherwise hold.
- CONV, one iteration per edge:
  - Add 3 to every BCD nibble ≥5, then shift {bcd_work, sh} left by 1.
  - After the 8th iteration: bcd<=final work value, busy<=0, state<=IDLE.
  - bcd therefore updates exactly 8 edges after the capture edge.
  - bcd_work is 12 bits and cleared on capture; no overflow, since 255 fits.
- din changes while busy are ignored.
  - On return to IDLE, din is compared against last_din again.
  - A mismatch starts a new conversion on the next edge, so the newest value always wins.
- bcd only ever changes to a complete result; no partial values are visible.
- Scan:
  - Free-running counter counts 0..SCAN_DIV-1.
  - On wrap, digit index advances 0→1→2→0 and an rotates left.
  - Scanning never stalls, including during CONV.
- seg is registered and updated on the same edge as an (1 cycle after digit index).
- seg is decoded from the committed bcd nibble of the selected digit.
- Codes: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90; blank = FF.
- Nibbles >9 are impossible; if they occur, decode to FF.
- Reset mid-conversion: abort immediately, all state returns to reset values, no stale bcd commit.
  - If din≠0 after reset, a new conversion starts on the first edge.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined:
  - Hundreds digit shows FF when its nibble is 0.
  - Tens digit shows FF when both hundreds and tens nibbles are 0.
  - Units digit is never blanked.
- Undefined: all three digits are always shown, e.g. 7 displays "007".
- bcd, busy and an behave identically in both builds.

Test Plan:
- Reset, din=0, SCAN_DIV=4 -> busy stays 0, bcd=000, an cycles 001→010→100→001 every 4 cycles, seg=C0 on every digit (no LZB).
- din=8'd255 -> busy=1 for 8 cycles, bcd=12'h255 on the 8th edge after capture; seg shows A4 (an=100), 92 (an=010), 92 (an=001).
- din=8'd7 with SEG_LZB_EN -> bcd=007; seg=FF for an=100 and an=010, F8 for an=001; without macro -> C0, C0, F8.
- din=8'd100, then din=8'd42 three cycles later (during busy) -> bcd becomes 100 first, then a second conversion starts immediately, and bcd=042 eight edges after that recapture.
- din=8'd199, assert rst at iteration 4 -> bcd=000, busy=0, an=001 asynchronously. Release with din=199 -> recapture on the first edge, bcd=199 eight edges later.
- Sweep din 0..255, each held until busy falls -> bcd matches the decimal value for every input.
